// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 memory subsystem.
// Requester IDs, FSM states and the program-area boundary.
package chip8_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 8;
    localparam int PROG_START = 'h200;

    typedef enum logic [1:0] {
        ID_NONE = 2'd0,
        ID_LD   = 2'd1,
        ID_CPU  = 2'd2,
        ID_DRW  = 2'd3
    } req_id_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/chip8_rr_pick.sv
// Two-way round-robin picker (purely combinational).
// Ports: req_a/req_b requests, last (1 = b served last),
// update enables a pick, pick_a/pick_b one-hot result.
module chip8_rr_pick (
    input  logic req_a,
    input  logic req_b,
    input  logic last,
    input  logic update,
    output logic pick_a,
    output logic pick_b
);

    // On a tie the side not served last wins.
    assign pick_a = update & req_a & (~req_b | last);
    assign pick_b = update & req_b & (~req_a | ~last);

endmodule

// File: rtl/chip8_mem_arbiter.sv
// Single-port arbiter/sequencer for CHIP-8 main memory.
// Ports: clk/reset; per master (ld, cpu, drw) req/we/addr/wdata/lock
// in, gnt/rvalid/rdata out; mem_* command bus; owner, prot_err, lock_err.
module chip8_mem_arbiter
    import chip8_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MEM_LAT  = 1,
    parameter int LOCK_MAX = 64,
    parameter int PROTECT  = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_lock,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lock,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              drw_req,
    input  logic              drw_we,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_wdata,
    input  logic              drw_lock,
    output logic              drw_gnt,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] drw_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        owner,
    output logic              prot_err,
    output logic              lock_err
);

    localparam int TMO_W = $clog2(LOCK_MAX + 1);
    localparam logic [1:0] LAT_LAST =
        (MEM_LAT > 0) ? 2'(MEM_LAT - 1) : 2'd0;

    state_t            state, state_nx;
    req_id_t           owner_q, cmd_id, win;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              last_drw;
    logic [TMO_W-1:0]  tmo;
    logic [1:0]        wait_cnt;
    logic [DATA_W-1:0] ld_q, cpu_q, drw_q;

    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              owner_req, sel_lock, blocked;
    logic              rr_en, pick_cpu, pick_drw;
    logic              iss, rv;

    assign rr_en = (state == ST_IDLE) && (owner_q == ID_NONE) && !ld_req;

    chip8_rr_pick u_rr (
        .req_a  (cpu_req),
        .req_b  (drw_req),
        .last   (last_drw),
        .update (rr_en),
        .pick_a (pick_cpu),
        .pick_b (pick_drw)
    );

    always_comb begin
        owner_req = 1'b0;
        case (owner_q)
            ID_LD:   owner_req = ld_req;
            ID_CPU:  owner_req = cpu_req;
            ID_DRW:  owner_req = drw_req;
            default: owner_req = 1'b0;
        endcase
    end

    always_comb begin
        sel_lock = 1'b0;
        case (cmd_id)
            ID_LD:   sel_lock = ld_lock;
            ID_CPU:  sel_lock = cpu_lock;
            ID_DRW:  sel_lock = drw_lock;
            default: sel_lock = 1'b0;
        endcase
    end

    always_comb begin
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        case (win)
            ID_LD: begin
                win_we    = ld_we;
                win_addr  = ld_addr;
                win_wdata = ld_wdata;
            end
            ID_CPU: begin
                win_we    = cpu_we;
                win_addr  = cpu_addr;
                win_wdata = cpu_wdata;
            end
            ID_DRW: begin
                win_we    = drw_we;
                win_addr  = drw_addr;
                win_wdata = drw_wdata;
            end
            default: ;
        endcase
    end

    // Loader writes always land; cpu/draw writes below the program
    // area are swallowed so the interpreter/font region survives bugs.
    assign blocked = (PROTECT != 0) && cmd_we && (cmd_id != ID_LD)
                   && (cmd_addr < ADDR_W'(PROG_START));

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        win      = ID_NONE;
        iss      = 1'b0;
        rv       = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        prot_err = 1'b0;
        lock_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (owner_q != ID_NONE) begin
                    if (owner_req)
                        win = owner_q;
                    else if (tmo == TMO_W'(LOCK_MAX - 1))
                        lock_err = 1'b1;
                end else if (ld_req) begin
                    win = ID_LD;
                end else if (pick_cpu) begin
                    win = ID_CPU;
                end else if (pick_drw) begin
                    win = ID_DRW;
                end
                if (win != ID_NONE) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                iss = 1'b1;
                if (cmd_we) begin
                    mem_we   = !blocked;
                    prot_err = blocked;
                    state_nx = ST_IDLE;
                end else begin
                    mem_re = 1'b1;
                    if (MEM_LAT == 0) begin
                        rv       = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == LAT_LAST) begin
                    rv       = 1'b1;
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        // An access cut short by reset never reports or issues anything.
        if (reset) begin
            iss      = 1'b0;
            rv       = 1'b0;
            mem_we   = 1'b0;
            mem_re   = 1'b0;
            prot_err = 1'b0;
            lock_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q   <= ID_NONE;
            cmd_id    <= ID_NONE;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            last_drw  <= 1'b1;
            tmo       <= '0;
            wait_cnt  <= 2'd0;
            ld_q      <= '0;
            cpu_q     <= '0;
            drw_q     <= '0;
        end else begin
            if (state == ST_IDLE && win != ID_NONE) begin
                cmd_id    <= win;
                cmd_we    <= win_we;
                cmd_addr  <= win_addr;
                cmd_wdata <= win_wdata;
            end
            if (iss) begin
                owner_q <= sel_lock ? cmd_id : ID_NONE;
                if (cmd_id == ID_CPU) last_drw <= 1'b0;
                if (cmd_id == ID_DRW) last_drw <= 1'b1;
            end else if (lock_err) begin
                owner_q <= ID_NONE;
            end
            if (state == ST_IDLE && owner_q != ID_NONE
                && !owner_req && !lock_err)
                tmo <= tmo + 1'b1;
            else
                tmo <= '0;
            wait_cnt <= (state == ST_WAIT) ? wait_cnt + 2'd1 : 2'd0;
            if (rv) begin
                case (cmd_id)
                    ID_LD:   ld_q  <= mem_rdata;
                    ID_CPU:  cpu_q <= mem_rdata;
                    ID_DRW:  drw_q <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign ld_gnt     = iss && (cmd_id == ID_LD);
    assign cpu_gnt    = iss && (cmd_id == ID_CPU);
    assign drw_gnt    = iss && (cmd_id == ID_DRW);
    assign ld_rvalid  = rv && (cmd_id == ID_LD);
    assign cpu_rvalid = rv && (cmd_id == ID_CPU);
    assign drw_rvalid = rv && (cmd_id == ID_DRW);

    // Read data is visible in the rvalid cycle itself, then held.
    assign ld_rdata  = ld_rvalid  ? mem_rdata : ld_q;
    assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_q;
    assign drw_rdata = drw_rvalid ? mem_rdata : drw_q;

    assign mem_addr  = cmd_addr;
    assign mem_wdata = cmd_wdata;
    assign owner     = owner_q;

endmodule

// File: doc/chip8_mem_arbiter.md
# chip8_mem_arbiter

Single-port arbiter and sequencer for the 4 KB CHIP-8 main memory, shared by three requesters: the ROM/font loader, the CPU fetch/execute unit, and the sprite draw engine (DXYN row reads). It sits between those masters and the memory array inside `chip8_top`. It serialises accesses, tracks read latency, and supports locked multi-byte bursts (sprite rows, FX33/FX55/FX65). It also protects the interpreter area from stray writes.

## Interface
- `ADDR_W`, 12, memory address width
- `DATA_W`, 8, memory data width
- `MEM_LAT`, 1, memory read latency in cycles (0..3)
- `LOCK_MAX`, 64, idle cycles a lock may be held with no request before forced release
- `PROTECT`, 1, when 1, CPU and draw writes to 0x000–0x1FF are dropped
- `clk` in 1, system clock; one clock for the whole block
- `reset` in 1, synchronous, active-high
- `{ld,cpu,drw}_req` in 1, access request; held until `_gnt`
- `{ld,cpu,drw}_we` in 1, 1 = write, 0 = read
- `{ld,cpu,drw}_addr` in ADDR_W, byte address
- `{ld,cpu,drw}_wdata` in DATA_W, write data
- `{ld,cpu,drw}_lock` in 1, keep ownership after this access
- `{ld,cpu,drw}_gnt` out 1, one-cycle pulse; the access is issued this cycle
- `{ld,cpu,drw}_rvalid` out 1, one-cycle pulse; `_rdata` is valid
- `{ld,cpu,drw}_rdata` out DATA_W, read data; holds its last value between pulses
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_we` out 1, `mem_re` out 1, memory command
- `mem_rdata` in DATA_W, valid MEM_LAT cycles after `mem_re`
- `owner` out 2, 0 = none, 1 = loader, 2 = cpu, 3 = draw; current lock holder
- `prot_err` out 1, pulse on a dropped protected write
- `lock_err` out 1, pulse on a forced lock release

## Operation
- States are IDLE, ISSUE and WAIT. There is one outstanding access at a time.
- IDLE, arbitration:
  - If `owner` ≠ 0, only the owner is eligible; other requests wait.
  - Otherwise the loader has strict priority. CPU and draw alternate round-robin via a `last` pointer, which toggles only when one of them is served.
  - A winner latches its `we`, `addr` and `wdata` into the command register, then the FSM moves to ISSUE.
- ISSUE:
  - Drives `mem_*` from the command register and pulses the winner's `_gnt`.
  - `owner` is set to the winner if its `_lock` is sampled high this cycle, and cleared otherwise.
  - A read with MEM_LAT = 0 captures `mem_rdata` into `_rdata` with `rvalid` in the same cycle, then returns to IDLE.
  - A read with MEM_LAT > 0 goes to WAIT. A write returns to IDLE.
- WAIT: counts MEM_LAT−1 cycles. On the final cycle it captures `mem_rdata`, pulses `_rvalid` and returns to IDLE.
- Protection: applies when PROTECT = 1 and a CPU/draw write has addr < 0x200.
  - `gnt` still pulses and `prot_err` pulses.
  - `mem_we` stays 0 and memory is unchanged.
  - Loader writes are never blocked.
- Lock timeout:
  - In IDLE with `owner` ≠ 0, a counter increments each cycle the owner's `req` is low. It resets to 0 on any owner request.
  - When the counter reaches LOCK_MAX, `owner` is cleared and `lock_err` pulses for one cycle.
  - An owner deasserting `_lock` with no request does not release the lock until its next issued access, or until timeout.
- Addresses are used as-is. 0xFFF is valid, and there is no wrap or increment inside the block.
- Reset:
  - FSM goes to IDLE, `owner` = 0, `last` = draw (so the CPU wins the first tie), timeout counter = 0.
  - All `gnt`/`rvalid`/`mem_we`/`mem_re`/`err` outputs are 0; `mem_addr`, `mem_wdata` and all `rdata` are 0.
  - An in-flight read is discarded and no `rvalid` is produced.

## Timing
- Request sampled in IDLE at cycle t. Issue and `gnt` occur at t+1. Read data arrives at t+1+MEM_LAT.
- Write throughput is 1 access per 2 cycles. Read throughput is 1 per 2+MEM_LAT cycles (MEM_LAT ≥ 1); with MEM_LAT = 0 it is 1 per 2.
- A requester must change or drop `req` in the cycle after `gnt`. A `req` still high in the cycle after `gnt` is treated as a new access.
- Simultaneous requests from all three: order is ld, then cpu/draw alternating. The loader can starve the others; this is accepted because the loader runs only at boot.
- `mem_re` and `mem_we` are never both high. Both are low outside ISSUE.

## Structure
- `chip8_pkg`: ADDR_W/DATA_W defaults, requester IDs (LD = 1, CPU = 2, DRW = 3), FSM state encoding, and the `PROG_START` = 0x200 constant.
- Sub-module `chip8_rr_pick`: two-way round-robin picker with inputs `req_a`, `req_b`, `last` and `update`, and outputs `pick_a`, `pick_b`. All other logic stays in `chip8_mem_arbiter`.

## Test plan
- CPU read of 0x200 (mem holds 0xA2), MEM_LAT = 1: `cpu_gnt` at t+1, `mem_re` = 1 with addr 0x200 at t+1, `cpu_rvalid` with `rdata` = 0xA2 at t+2.
- `cpu_req` and `drw_req` held continuously: grants alternate cpu, drw, cpu, drw starting with cpu. `ld_req` asserted midway wins the next arbitration.
- Draw engine locks for a 5-byte sprite read (0x050–0x054) while the CPU requests: draw is granted 5 times consecutively, then the CPU is granted after draw drops `lock`.
- CPU write 0x55 to 0x1FF with PROTECT = 1: `cpu_gnt` and `prot_err` pulse, `mem_we` = 0, and a subsequent read returns the old value. Loader write 0x55 to 0x1FF succeeds.
- Draw holds `lock` but stops requesting: after LOCK_MAX = 64 idle cycles `lock_err` pulses and `owner` = 0. A pending CPU request is granted on the next arbitration.
- `reset` asserted in WAIT during a CPU read: no `cpu_rvalid` fires, all outputs are 0 on the next cycle, and the first post-reset cpu/draw tie goes to the CPU.
